// File: rtl/gumnut_pkg.sv
// Shared types and constants for the Gumnut instruction-fetch stage.
package gumnut_pkg;

   // Opcode classes presented to the control unit.
   localparam logic [6:0] OP_ALU_IMM = 7'b0000000;
   localparam logic [6:0] OP_ALU_REG = 7'b0000001;
   localparam logic [6:0] OP_MEM     = 7'b0000010;
   localparam logic [6:0] OP_SHIFT   = 7'b0000110;
   localparam logic [6:0] OP_BRANCH  = 7'b0111110;
   localparam logic [6:0] OP_JUMP    = 7'b0011110;
   localparam logic [6:0] OP_MISC    = 7'b1111110;

   // PC operations commanded by the control unit; codes 8..15 behave as hold.
   typedef enum logic [3:0] {
      PC_HOLD   = 4'd0,
      PC_INC    = 4'd1,
      PC_BRANCH = 4'd2,
      PC_JUMP   = 4'd3,
      PC_JSB    = 4'd4,
      PC_RET    = 4'd5,
      PC_INT    = 4'd6,
      PC_RETI   = 4'd7
   } pc_oper_t;

   // Instruction-bus master states.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [6:0] op;
      logic [2:0] func;
   } decode_t;

   // Prefix-coded decode: the number of leading ones selects the class.
   function automatic decode_t decode_ir(input logic [17:0] ir);
      decode_t d;
      d.op   = OP_ALU_IMM;
      d.func = ir[16:14];
      casez (ir[17:12])
         6'b0?????: begin d.op = OP_ALU_IMM; d.func = ir[16:14];               end
         6'b10????: begin d.op = OP_MEM;     d.func = {1'b0, ir[15:14]};       end
         6'b110???: begin d.op = OP_ALU_REG; d.func = ir[2:0];                 end
         6'b1110??: begin d.op = OP_SHIFT;   d.func = {1'b0, ir[1:0]};         end
         6'b11110?: begin d.op = OP_BRANCH;  d.func = {1'b0, ir[11:10]};       end
         6'b111110: begin d.op = OP_JUMP;    d.func = {2'b00, ir[10]};         end
         6'b111111: begin d.op = OP_MISC;    d.func = ir[10:8];                end
         default:   begin d.op = OP_ALU_IMM; d.func = ir[16:14];               end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/gumnut_ret_stack.sv
// Circular return-address stack. Pushing when full overwrites the oldest
// entry; popping when empty yields EMPTY_VAL. Both misuse cases set a sticky
// error flag that only reset clears.
module gumnut_ret_stack
   import gumnut_pkg::*;
#(
   parameter int              AW        = 12,
   parameter int              DEPTH     = 8,
   parameter logic [AW-1:0]   EMPTY_VAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [AW-1:0] i_push_data,
   output logic [AW-1:0] o_pop_data,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [AW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_top;      // next slot to write
   logic [PW:0]   r_count;    // live entries, saturates at DEPTH
   logic          r_err;
   logic [PW-1:0] w_rd_idx;

   assign w_rd_idx   = r_top - 1'b1;
   assign o_full     = (r_count == FULL_CNT);
   assign o_empty    = (r_count == '0);
   assign o_err      = r_err;
   // Pop data must be available in the same cycle the PC is loaded from it.
   assign o_pop_data = o_empty ? EMPTY_VAL : r_mem[w_rd_idx];

   // Storage write; contents need no reset since the count gates every read.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_top] <= i_push_data;
      end
   end

   // Pointer, occupancy and sticky error tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_top   <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else if (i_push) begin
         r_top <= r_top + 1'b1;
         if (o_full) begin
            r_err <= 1'b1;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end else if (i_pop) begin
         if (o_empty) begin
            r_err <= 1'b1;
         end else begin
            r_top   <= w_rd_idx;
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/gumnut_fetch_unit.sv
// Gumnut instruction-fetch stage: PC, IR, return stack, saved interrupt PC,
// instruction-bus master and IR decode for the control unit.
module gumnut_fetch_unit
   import gumnut_pkg::*;
#(
   parameter int            IW          = 18,
   parameter int            AW          = 12,
   parameter int            STACK_DEPTH = 8,
   parameter logic [AW-1:0] RESET_PC    = 12'h000,
   parameter logic [AW-1:0] INT_VECTOR  = 12'h001
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fetch_i,
   input  logic          inst_ack_i,
   input  logic [IW-1:0] inst_dat_i,
   output logic          inst_cyc_o,
   output logic          inst_stb_o,
   output logic [AW-1:0] inst_adr_o,
   input  logic          pc_en_i,
   input  logic [3:0]    pc_oper_i,
   output logic [IW-1:0] ir_o,
   output logic          ir_valid_o,
   output logic [6:0]    op_o,
   output logic [2:0]    func_o,
   output logic [AW-1:0] pc_o,
   output logic          stack_full_o,
   output logic          stack_empty_o,
   output logic          stack_err_o
);

   fetch_state_t  r_state;
   fetch_state_t  w_state_next;
   logic          w_cyc;
   logic          w_ack_take;

   logic [AW-1:0] r_pc;
   logic [AW-1:0] r_saved_pc;
   logic [AW-1:0] r_adr;
   logic [IW-1:0] r_ir;
   logic          r_ir_valid;

   logic [AW-1:0] w_pc_next;
   logic          w_save_pc;
   logic          w_push;
   logic          w_pop;
   logic [AW-1:0] w_pop_data;
   logic [AW-1:0] w_disp;
   logic [AW-1:0] w_addr;
   decode_t       w_dec;

   assign w_disp     = {{(AW-8){r_ir[7]}}, r_ir[7:0]};
   assign w_addr     = r_ir[11:0];
   assign w_ack_take = (r_state == ST_BUS) && inst_ack_i;

   // Bus state register; reset drops any cycle in flight at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next bus state and strobe outputs; a started cycle runs until ack.
   always_comb begin
      w_state_next = r_state;
      w_cyc        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (fetch_i) begin
               w_state_next = ST_BUS;
            end
         end
         ST_BUS: begin
            w_cyc = 1'b1;
            if (inst_ack_i) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Next PC: a commanded operation overrides the post-fetch increment.
   always_comb begin
      w_pc_next = r_pc;
      w_save_pc = 1'b0;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      if (pc_en_i) begin
         case (pc_oper_i)
            PC_HOLD:   w_pc_next = r_pc;
            PC_INC:    w_pc_next = r_pc + 1'b1;
            PC_BRANCH: w_pc_next = r_pc + w_disp;
            PC_JUMP:   w_pc_next = w_addr;
            PC_JSB: begin
               w_push    = 1'b1;
               w_pc_next = w_addr;
            end
            PC_RET: begin
               w_pop     = 1'b1;
               w_pc_next = w_pop_data;
            end
            PC_INT: begin
               w_save_pc = 1'b1;
               w_pc_next = INT_VECTOR;
            end
            PC_RETI:   w_pc_next = r_saved_pc;
            default:   w_pc_next = r_pc;
         endcase
      end else if (w_ack_take) begin
         w_pc_next = r_pc + 1'b1;
      end
   end

   // PC and saved interrupt PC registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_saved_pc <= '0;
      end else begin
         r_pc <= w_pc_next;
         if (w_save_pc) begin
            r_saved_pc <= r_pc;
         end
      end
   end

   // Fetch address capture, IR load on ack and the one-cycle valid pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_adr      <= '0;
         r_ir       <= '0;
         r_ir_valid <= 1'b0;
      end else begin
         r_ir_valid <= w_ack_take;
         if (w_ack_take) begin
            r_ir <= inst_dat_i;
         end
         if ((r_state == ST_IDLE) && fetch_i) begin
            r_adr <= r_pc;
         end
      end
   end

   gumnut_ret_stack #(
      .AW        (AW),
      .DEPTH     (STACK_DEPTH),
      .EMPTY_VAL (RESET_PC)
   ) u_ret_stack (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_push_data (r_pc),
      .o_pop_data  (w_pop_data),
      .o_full      (stack_full_o),
      .o_empty     (stack_empty_o),
      .o_err       (stack_err_o)
   );

   assign w_dec      = decode_ir(r_ir[17:0]);
   assign op_o       = w_dec.op;
   assign func_o     = w_dec.func;
   assign inst_cyc_o = w_cyc;
   assign inst_stb_o = w_cyc;
   assign inst_adr_o = r_adr;
   assign ir_o       = r_ir;
   assign ir_valid_o = r_ir_valid;
   assign pc_o       = r_pc;

endmodule
